ds_controller: RTL and testbench
================================

Name: ds_controller

Overview:
- Data-store controller: the write-side counterpart of the data-load path between four cores and the 64-bit-row data memory.
- Accepts 16-bit store requests from up to four cores in one transaction.
- Groups requests that hit the same memory row and commits each group as one 64-bit row write.
- Default build uses read-modify-write; DS_WMASK_EN selects masked writes instead.

Parameters:
RD_LAT, 1, data memory read latency in cycles (legal 1..4); data_in valid RD_LAT cycles after the MEMREAD cycle.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
MW1..MW4  input  1 each  store request from core i (level, held until DONE)
MADDR1..MADDR4  input  16 each  word address from core i
DIN1..DIN4  input  16 each  store data from core i
data_in  input  64  row read data from data memory
MEMREAD  output  1  row read strobe to data memory
MEMWRITE  output  1  row write strobe to data memory
MEMADDR  output  16  row address = {2'b0, addr[15:2]}
MEMDATA  output  64  row write data
MEMWMASK  output  4  lane write enables; 4'b1111 in RMW build
BUSY  output  1  transaction in progress
DONE  output  1  one-cycle pulse: last row write of the transaction

Behaviour:
- Interface fixed: one clock (clk); reset synchronous, active-high (reset). Polarity and synchronicity are not configurable.
- Reset values: MEMREAD=0, MEMWRITE=0, MEMADDR=0, MEMDATA=0, MEMWMASK=0, BUSY=0, DONE=0.
- Reset also clears the pending mask, capture registers and state; next state is IDLE.
- Lane mapping matches the load path. addr[1:0]=k selects bits [63-16k : 48-16k]; lane k maps to MEMWMASK[3-k].
- IDLE:
  - If any MWi=1, capture MADDRi and DINi for all i.
  - Set pending P={MW4,MW3,MW2,MW1}.
  - Move to READ in the RMW build, or to WRITE in the DS_WMASK_EN build.
- Group selection:
  - Leader = lowest-index pending core; row R = leader addr[15:2].
  - Group = all pending cores whose addr[15:2] equals R.
  - Groups are committed in leader-index order.
- READ (1 cycle): MEMREAD=1, MEMADDR={2'b0,R}.
- WAIT (RD_LAT cycles): data_in is captured into the row buffer at the end of the last WAIT cycle.
- WRITE (1 cycle): MEMWRITE=1, MEMADDR={2'b0,R}.
  - MEMDATA = row buffer with each group lane replaced by that core's DIN.
  - Same-word conflict within a group: the highest-index core wins.
  - Group bits are cleared from P.
  - If P becomes 0: DONE=1 this cycle, next state RELEASE. Otherwise next group: READ (RMW) or WRITE (mask build).
- RELEASE: wait until all MWi=0, then IDLE. A new transaction is never accepted while any MW is still held from the previous one.
- BUSY=1 in every state except IDLE.
- Cycles per group: RD_LAT+2 (RMW) or 1 (mask build).
- MEMREAD and MEMWRITE are never high in the same cycle.
- MW changes after capture are ignored until IDLE.
- Reset mid-transaction:
  - Rows already written stay written.
  - No MEMREAD/MEMWRITE in the reset cycle or after it.
  - Uncommitted groups are dropped.

Optional Feature:
DS_WMASK_EN
- Defined:
  - READ and WAIT states are omitted; MEMREAD is held 0.
  - WRITE drives MEMWMASK = OR of the group's lane bits; unmasked MEMDATA lanes are 0.
  - One cycle per group.
- Undefined:
  - Read-modify-write as described above; MEMWMASK=4'b1111 during WRITE, 0 otherwise.
  - RD_LAT is used.

Test Plan:
1. RD_LAT=1; MADDR1..4=0x0010..0x0013, DIN=A1A1,B2B2,C3C3,D4D4, all MW=1 at cycle 0 -> READ at cycle 1 with MEMADDR=0x0004; WRITE at cycle 3 with MEMDATA=A1A1B2B2C3C3D4D4; DONE=1 at cycle 3.
2. Four distinct rows, MADDRi=0x0040*i+1, data_in=0xFFFF_FFFF_FFFF_FFFF -> four READ/WAIT/WRITE groups in core order 1..4; each write has only lane 1 replaced by DINi; DONE at cycle 12.
3. MADDR1=MADDR3=0x0021, DIN1=1111, DIN3=3333, only MW1 and MW3 high -> single group; lane 1 (bits [47:32]) =3333; other lanes come from data_in.
4. Only MW2=1 with MADDR2=0x0007 -> one group at MEMADDR=0x0001; lane 3 written; all other cores' inputs ignored.
5. Reset asserted during WAIT of the first of two groups -> MEMWRITE never asserts; all outputs 0 on the next cycle; state IDLE; DONE never pulses.
6. DS_WMASK_EN: stimulus of test 1 -> WRITE at cycle 1 with MEMWMASK=1111, MEMREAD never 1. Single core at MADDR=0x0006 -> MEMWMASK=0010, MEMDATA[31:16]=DIN.

Source files
------------

// File: rtl/ds_controller.sv
// ds_controller -- data-store controller between four cores and a 64-bit-row
// data memory. It accepts up to four 16-bit store requests per transaction.
// Requests that hit the same row form one group, and each group is committed
// as a single row write.
//
// Build option: `define DS_WMASK_EN selects masked writes, which take one cycle
// per group with no read. The default build does read-modify-write, which takes
// RD_LAT+2 cycles per group.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   MW1..MW4              store request per core (level, held until DONE)
//   MADDR1..MADDR4        16-bit word address per core
//   DIN1..DIN4            16-bit store data per core
//   data_in               64-bit row read data (RD_LAT cycles after MEMREAD)
//   MEMREAD/MEMWRITE      row read / write strobes
//   MEMADDR               row address {2'b0, addr[15:2]}
//   MEMDATA, MEMWMASK     row write data and lane enables (lane k -> bit 3-k)
//   BUSY                  high in every state except IDLE
//   DONE                  pulses with the last row write of a transaction
module ds_controller #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MW1,
  input  logic        MW2,
  input  logic        MW3,
  input  logic        MW4,
  input  logic [15:0] MADDR1,
  input  logic [15:0] MADDR2,
  input  logic [15:0] MADDR3,
  input  logic [15:0] MADDR4,
  input  logic [15:0] DIN1,
  input  logic [15:0] DIN2,
  input  logic [15:0] DIN3,
  input  logic [15:0] DIN4,
  input  logic [63:0] data_in,
  output logic        MEMREAD,
  output logic        MEMWRITE,
  output logic [15:0] MEMADDR,
  output logic [63:0] MEMDATA,
  output logic [3:0]  MEMWMASK,
  output logic        BUSY,
  output logic        DONE
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_WRITE, S_REL} state_t;

  state_t            r_state, w_next;
  logic [3:0]        r_pend;
  logic [3:0][15:0]  r_addr, r_din;
  logic [3:0]        w_mw, w_grp;
  logic [13:0]       w_row;
  logic [63:0]       w_wdata;
  logic [3:0]        w_wmask;

`ifndef DS_WMASK_EN
  localparam logic [2:0] WAIT_LAST = 3'(RD_LAT - 1);
  logic [63:0] r_rowbuf;
  logic [2:0]  r_wcnt;
`else
  logic w_unused;
  assign w_unused = (^data_in) ^ (RD_LAT == 0);
`endif

  assign w_mw = {MW4, MW3, MW2, MW1};

  // Leader is the lowest-index pending core. The descending scan leaves the
  // lowest index's row in w_row.
  always_comb begin
    w_row = '0;
    w_grp = '0;
    for (int i = 3; i >= 0; i--)
      if (r_pend[i]) w_row = r_addr[i][15:2];
    for (int i = 0; i < 4; i++)
      w_grp[i] = r_pend[i] && (r_addr[i][15:2] == w_row);
  end

  // Lane merge. Ascending core order lets the highest-index core overwrite a
  // shared word.
  always_comb begin
`ifdef DS_WMASK_EN
    w_wdata = '0;
`else
    w_wdata = r_rowbuf;
`endif
    w_wmask = '0;
    for (int i = 0; i < 4; i++) begin
      if (w_grp[i]) begin
        case (r_addr[i][1:0])
          2'd0: begin w_wdata[63:48] = r_din[i]; w_wmask[3] = 1'b1; end
          2'd1: begin w_wdata[47:32] = r_din[i]; w_wmask[2] = 1'b1; end
          2'd2: begin w_wdata[31:16] = r_din[i]; w_wmask[1] = 1'b1; end
          default: begin w_wdata[15:0] = r_din[i]; w_wmask[0] = 1'b1; end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    MEMREAD  = 1'b0;
    MEMWRITE = 1'b0;
    MEMADDR  = '0;
    MEMDATA  = '0;
    MEMWMASK = '0;
    DONE     = 1'b0;
    BUSY     = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (|w_mw) begin
`ifdef DS_WMASK_EN
          w_next = S_WRITE;
`else
          w_next = S_READ;
`endif
        end
      end
`ifndef DS_WMASK_EN
      S_READ: begin
        MEMREAD = 1'b1;
        MEMADDR = {2'b00, w_row};
        w_next  = S_WAIT;
      end
      S_WAIT: begin
        if (r_wcnt == WAIT_LAST) w_next = S_WRITE;
      end
`endif
      S_WRITE: begin
        MEMWRITE = 1'b1;
        MEMADDR  = {2'b00, w_row};
        MEMDATA  = w_wdata;
`ifdef DS_WMASK_EN
        MEMWMASK = w_wmask;
        w_next   = S_WRITE;
`else
        MEMWMASK = 4'b1111;
        w_next   = S_READ;
`endif
        if ((r_pend & ~w_grp) == 4'b0000) begin
          DONE   = 1'b1;
          w_next = S_REL;
        end
      end
      S_REL: begin
        if (!(|w_mw)) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // Outputs are decoded from the current state. Masking them with reset keeps
    // the strobes quiet in the same cycle that reset is sampled.
    if (reset) begin
      MEMREAD  = 1'b0;
      MEMWRITE = 1'b0;
      MEMADDR  = '0;
      MEMDATA  = '0;
      MEMWMASK = '0;
      DONE     = 1'b0;
      BUSY     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend   <= '0;
      r_addr   <= '0;
      r_din    <= '0;
`ifndef DS_WMASK_EN
      r_rowbuf <= '0;
      r_wcnt   <= '0;
`endif
    end else begin
      if (r_state == S_IDLE && (|w_mw)) begin
        r_pend <= w_mw;
        r_addr <= {MADDR4, MADDR3, MADDR2, MADDR1};
        r_din  <= {DIN4, DIN3, DIN2, DIN1};
      end
      if (r_state == S_WRITE) r_pend <= r_pend & ~w_grp;
`ifndef DS_WMASK_EN
      if (r_state == S_WAIT) r_wcnt <= r_wcnt + 3'd1;
      else                   r_wcnt <= '0;
      if (r_state == S_WAIT && r_wcnt == WAIT_LAST) r_rowbuf <= data_in;
`endif
    end
  end

endmodule

// File: tb/tb_ds_controller.sv
module tb_ds_controller;
  localparam int L = 1;
`ifdef DS_WMASK_EN
  localparam bit MASKB = 1'b1;
`else
  localparam bit MASKB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        MW1, MW2, MW3, MW4;
  logic [15:0] MADDR1, MADDR2, MADDR3, MADDR4;
  logic [15:0] DIN1, DIN2, DIN3, DIN4;
  logic [63:0] data_in;
  logic        MEMREAD, MEMWRITE, BUSY, DONE;
  logic [15:0] MEMADDR;
  logic [63:0] MEMDATA;
  logic [3:0]  MEMWMASK;

  ds_controller #(.RD_LAT(L)) dut (
    .clk(clk), .reset(reset),
    .MW1(MW1), .MW2(MW2), .MW3(MW3), .MW4(MW4),
    .MADDR1(MADDR1), .MADDR2(MADDR2), .MADDR3(MADDR3), .MADDR4(MADDR4),
    .DIN1(DIN1), .DIN2(DIN2), .DIN3(DIN3), .DIN4(DIN4),
    .data_in(data_in),
    .MEMREAD(MEMREAD), .MEMWRITE(MEMWRITE), .MEMADDR(MEMADDR),
    .MEMDATA(MEMDATA), .MEMWMASK(MEMWMASK), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 clk = ~clk;

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Memory contents as a pure function of the row.
  function automatic logic [63:0] memf(input logic [13:0] r);
    logic [15:0] a;
    a = {2'b00, r};
    return {a, ~a, a ^ 16'hA5A5, a + 16'h1234};
  endfunction

  // Transaction stimulus and expected groups.
  logic [3:0]  tmw;
  logic [15:0] ta[4];
  logic [15:0] td[4];
  logic [13:0] exp_row[4];
  logic [63:0] exp_data[4];
  logic [3:0]  exp_mask[4];
  int          ng;
  logic [63:0] lw_data;

  // Each pending leader in index order opens a group over its row. Each word of
  // that row takes the data of the highest-index member that addresses it.
  task automatic model();
    logic [3:0]  done_m;
    logic [13:0] row;
    logic [63:0] d;
    logic [3:0]  m;
    int          w;
    done_m = '0;
    ng = 0;
    for (int ld = 0; ld < 4; ld++) begin
      if (tmw[ld] && !done_m[ld]) begin
        row = ta[ld][15:2];
        d = MASKB ? 64'd0 : memf(row);
        m = '0;
        for (int k = 0; k < 4; k++) begin
          w = -1;
          for (int i = 0; i < 4; i++)
            if (tmw[i] && !done_m[i] && ta[i][15:2] == row && int'(ta[i][1:0]) == k) w = i;
          if (w >= 0) begin
            d[63-16*k -: 16] = td[w];
            m[3-k] = 1'b1;
          end
        end
        for (int i = 0; i < 4; i++)
          if (tmw[i] && ta[i][15:2] == row) done_m[i] = 1'b1;
        exp_row[ng]  = row;
        exp_data[ng] = d;
        exp_mask[ng] = MASKB ? m : 4'hF;
        ng++;
      end
    end
  endtask

  task automatic drive();
    {MW4, MW3, MW2, MW1} = tmw;
    MADDR1 = ta[0]; MADDR2 = ta[1]; MADDR3 = ta[2]; MADDR4 = ta[3];
    DIN1 = td[0]; DIN2 = td[1]; DIN3 = td[2]; DIN4 = td[3];
  endtask

  // Call at a negedge with the DUT idle. Cycle 0 is the IDLE capture cycle.
  task automatic run(input int hold);
    int per, last, ph, g, rdcnt;
    logic exp_rd, exp_wr;
    logic [13:0] rdrow;
    drive();
    model();
    per = MASKB ? 1 : L + 2;
    last = ng * per;
    rdcnt = -1;
    rdrow = '0;
    for (int c = 0; c <= last + hold; c++) begin
      #1;
      exp_rd = 1'b0; exp_wr = 1'b0; g = 0;
      if (c >= 1 && c <= last) begin
        ph = (c - 1) % per;
        g  = (c - 1) / per;
        exp_rd = !MASKB && ph == 0;
        exp_wr = (ph == per - 1);
      end
      chk("busy", BUSY, c >= 1);
      chk("memread", MEMREAD, exp_rd);
      chk("memwrite", MEMWRITE, exp_wr);
      chk("done", DONE, exp_wr && g == ng - 1);
      if (exp_rd) chk("rd_addr", MEMADDR, {2'b00, exp_row[g]});
      if (exp_wr) begin
        chk("wr_addr", MEMADDR, {2'b00, exp_row[g]});
        chk("wr_data", MEMDATA, exp_data[g]);
        chk("wr_mask", MEMWMASK, exp_mask[g]);
        lw_data = MEMDATA;
      end else begin
        chk("idle_mask", MEMWMASK, 4'h0);
      end
      // Row data is valid only in the last wait cycle. Other cycles carry junk.
      if (rdcnt > 0) rdcnt--;
      if (rdcnt == 0) begin
        data_in = memf(rdrow);
        rdcnt = -1;
      end else begin
        data_in = {$urandom, $urandom};
      end
      if (exp_rd) begin
        rdcnt = L;
        rdrow = exp_row[g];
      end
      // Address and data changes after capture must be ignored.
      if (c == 1) begin
        MADDR1 = 16'($urandom); MADDR2 = 16'($urandom);
        MADDR3 = 16'($urandom); MADDR4 = 16'($urandom);
        DIN1 = 16'($urandom); DIN2 = 16'($urandom);
        DIN3 = 16'($urandom); DIN4 = 16'($urandom);
      end
      @(negedge clk);
    end
    {MW4, MW3, MW2, MW1} = 4'b0000;
    #1;
    chk("rel_busy", BUSY, 1'b1);
    chk("rel_wr", MEMWRITE, 1'b0);
    @(negedge clk);
    #1;
    chk("idle_busy", BUSY, 1'b0);
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rd"}, MEMREAD, 1'b0);
    chk({tag, "_wr"}, MEMWRITE, 1'b0);
    chk({tag, "_addr"}, MEMADDR, 16'h0);
    chk({tag, "_data"}, MEMDATA, 64'h0);
    chk({tag, "_mask"}, MEMWMASK, 4'h0);
    chk({tag, "_busy"}, BUSY, 1'b0);
    chk({tag, "_done"}, DONE, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    tmw = '0;
    for (int i = 0; i < 4; i++) begin ta[i] = '0; td[i] = '0; end
    drive();
    data_in = '0;
    lw_data = '0;
    repeat (2) @(negedge clk);
    #1 check_zero("rst");
    @(negedge clk);
    reset = 1'b0;
    #1 check_zero("post_rst");
    @(negedge clk);

    // All four cores hit one row.
    tmw = 4'hF;
    ta[0] = 16'h0010; ta[1] = 16'h0011; ta[2] = 16'h0012; ta[3] = 16'h0013;
    td[0] = 16'hA1A1; td[1] = 16'hB2B2; td[2] = 16'hC3C3; td[3] = 16'hD4D4;
    run(0);
    chk("t1_data", lw_data, 64'hA1A1B2B2C3C3D4D4);

    // Four distinct rows, lane 1 each.
    for (int i = 0; i < 4; i++) begin
      ta[i] = 16'(16'h0040 * (i + 1) + 1);
      td[i] = 16'h1000 * 16'(i + 1) + 16'h0ABC;
    end
    run(2);

    // Same-word conflict: the higher-index core wins.
    tmw = 4'b0101;
    ta[0] = 16'h0021; ta[2] = 16'h0021; td[0] = 16'h1111; td[2] = 16'h3333;
    ta[1] = 16'h0500; ta[3] = 16'h0900;
    run(1);

    // A single core. The other cores' inputs are ignored.
    tmw = 4'b0010;
    ta[0] = 16'h0044; ta[1] = 16'h0007; ta[2] = 16'h0101; ta[3] = 16'h0202;
    td[1] = 16'h7777;
    run(0);

    // Masked-build single-lane case (lane 2).
    tmw = 4'b0001;
    ta[0] = 16'h0006; td[0] = 16'h5A5A;
    run(0);

    // Random transactions over a few rows, so that groups form.
    for (int n = 0; n < 40; n++) begin
      logic [13:0] base;
      base = 14'($urandom_range(0, 1000));
      tmw = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) begin
        ta[i] = {base + 14'($urandom_range(0, 2)), 2'($urandom_range(0, 3))};
        td[i] = 16'($urandom);
      end
      run(int'($urandom_range(0, 3)));
    end

    // Reset in the middle of a two-group transaction (cycle 2 = WAIT in RMW).
    tmw = 4'b0011;
    ta[0] = 16'h0100; ta[1] = 16'h0200; td[0] = 16'hDEAD; td[1] = 16'hBEEF;
    drive();
    #1 chk("mr_c0_busy", BUSY, 1'b0);
    @(negedge clk);
    #1 chk("mr_c1_rd", MEMREAD, !MASKB);
    @(negedge clk);
    reset = 1'b1;
    tmw = 4'b0000;
    drive();
    #1;
    chk("mr_rd", MEMREAD, 1'b0);
    chk("mr_wr", MEMWRITE, 1'b0);
    chk("mr_done", DONE, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1 check_zero("mr_after");
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
